// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : One-deep pipeline register with a skid slot for an instruction
//             payload. Upstream ready depends only on registered state, so
//             there is no combinational path from out_ready to in_ready.
//             Flush drops everything held and incoming. A saturating counter
//             records stalled output cycles.
//  Ports    : clk, rst (sync, active-high)
//             in_valid / in_ready / in_* : upstream handshake and payload
//             flush                      : discard held and incoming entries
//             out_valid / out_ready / out_* : downstream handshake, payload
//             occupancy                  : held entries (0..2)
//             stall_cnt                  : saturating count of stalled cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int OP_W   = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rt,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rt;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    payload_t         oreg_q, oreg_d;
    payload_t         sreg_q, sreg_d;
    logic             oreg_valid_q, oreg_valid_d;
    logic             sreg_valid_q, sreg_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    payload_t w_in_pay;
    logic     w_in_fire;
    logic     w_out_fire;

    assign w_in_pay = '{opcode: in_opcode, a: in_a, b: in_b, imm: in_imm,
                        rd: in_rd, rt: in_rt, ctrl: in_ctrl};

    // The skid slot being empty is the only condition for accepting; this
    // keeps in_ready a pure function of registered state (plus reset).
    assign in_ready   = ~sreg_valid_q & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = oreg_valid_q & out_ready;

    always_comb begin
        oreg_d       = oreg_q;
        sreg_d       = sreg_q;
        oreg_valid_d = oreg_valid_q;
        sreg_valid_d = sreg_valid_q;

        if (flush) begin
            // Data fields keep their last value; only the valid bits drop.
            oreg_valid_d = 1'b0;
            sreg_valid_d = 1'b0;
        end else if (!oreg_valid_q || w_out_fire) begin
            // Output register is free (or draining) this cycle.
            if (sreg_valid_q) begin
                // Older skid entry goes first. in_ready was low, so no
                // input can arrive in the same cycle.
                oreg_d       = sreg_q;
                oreg_valid_d = 1'b1;
                sreg_valid_d = 1'b0;
            end else if (w_in_fire) begin
                oreg_d       = w_in_pay;
                oreg_valid_d = 1'b1;
            end else begin
                oreg_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            // Output is stalled: park the new entry in the skid slot.
            sreg_d       = w_in_pay;
            sreg_valid_d = 1'b1;
        end
    end

    // Counts regardless of flush, so a stalled cycle that is also flushed
    // is still recorded.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (oreg_valid_q && !out_ready && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_q       <= '0;
            sreg_q       <= '0;
            oreg_valid_q <= 1'b0;
            sreg_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            oreg_q       <= oreg_d;
            sreg_q       <= sreg_d;
            oreg_valid_q <= oreg_valid_d;
            sreg_valid_q <= sreg_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid  = oreg_valid_q;
    assign out_opcode = oreg_q.opcode;
    assign out_a      = oreg_q.a;
    assign out_b      = oreg_q.b;
    assign out_imm    = oreg_q.imm;
    assign out_rd     = oreg_q.rd;
    assign out_rt     = oreg_q.rt;
    // A bubble must never present reg_wr/mem_wr downstream.
    assign out_ctrl   = oreg_valid_q ? oreg_q.ctrl : '0;
    assign occupancy  = {1'b0, oreg_valid_q} + {1'b0, sreg_valid_q};
    assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Purpose  : Directed vectors and a queue-model traffic phase for
//             pipe_stage_skid (CNT_W = 4 so saturation is reachable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int OP_W   = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [DATA_W-1:0] in_a, in_b, in_imm;
    logic [REG_W-1:0]  in_rd, in_rt;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_opcode;
    logic [DATA_W-1:0] out_a, out_b, out_imm;
    logic [REG_W-1:0]  out_rd, out_rt;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W),
        .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_rd(in_rd), .in_rt(in_rt), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .out_rd(out_rd), .out_rt(out_rt),
        .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and samples both sit 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OP_W-1:0] op,
                         input logic [CTRL_W-1:0] ctrl,
                         input logic [DATA_W-1:0] a);
        in_valid  = v;
        in_opcode = op;
        in_ctrl   = ctrl;
        in_a      = a;
    endtask

    // Model for the random phase: queue of {opcode, a} in arrival order.
    logic [OP_W+DATA_W-1:0] sb[$];

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_b = 32'h0000_B0B0; in_imm = 32'h0000_1111;
        in_rd = 4'h3; in_rt = 4'h5;
        drive(1'b0, '0, '0, '0);

        // ---------------- reset ----------------
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        drive(1'b1, 5'd1, 8'h01, 32'hA1);
        step();
        check("str_op1", out_opcode, 1);
        check("str_occ1", occupancy, 1);
        check("str_ctrl1", out_ctrl, 8'h01);
        drive(1'b1, 5'd2, 8'h01, 32'hA2);
        step();
        check("str_op2", out_opcode, 2);
        check("str_occ2", occupancy, 1);
        drive(1'b1, 5'd3, 8'h02, 32'hA3);
        step();
        check("str_op3", out_opcode, 3);
        check("str_a3", out_a, 32'hA3);
        check("str_occ3", occupancy, 1);
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        step();
        check("str_bubble_valid", out_valid, 0);
        check("str_bubble_ctrl", out_ctrl, 0);
        check("str_bubble_hold_op", out_opcode, 3);
        check("str_stall0", stall_cnt, 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        drive(1'b1, 5'd10, 8'h03, 32'hB10);
        step();
        check("bp_op10", out_opcode, 10);
        check("bp_occ1", occupancy, 1);
        check("bp_rdy1", in_ready, 1);
        drive(1'b1, 5'd11, 8'h03, 32'hB11);
        step();
        check("bp_occ2", occupancy, 2);
        check("bp_rdy0", in_ready, 0);
        check("bp_stable_a", out_opcode, 10);
        drive(1'b1, 5'd12, 8'h03, 32'hB12);
        step();
        check("bp_occ2_hold", occupancy, 2);
        check("bp_stable_b", out_opcode, 10);
        check("bp_stall2", stall_cnt, 2);
        out_ready = 1'b1;
        step();
        check("bp_rel_op11", out_opcode, 11);
        check("bp_rel_occ", occupancy, 1);
        check("bp_rel_rdy", in_ready, 1);
        step();
        check("bp_rel_op12", out_opcode, 12);
        check("bp_rel_a12", out_a, 32'hB12);
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        step();
        check("bp_drain_valid", out_valid, 0);
        check("bp_drain_occ", occupancy, 0);

        // ---------------- flush at occupancy 2 ----------------
        out_ready = 1'b0;
        drive(1'b1, 5'd20, 8'h01, 32'hC20);
        step();
        drive(1'b1, 5'd21, 8'h01, 32'hC21);
        step();
        check("fl_occ2", occupancy, 2);
        check("fl_stall3", stall_cnt, 3);
        flush = 1'b1;
        drive(1'b1, 5'd22, 8'h01, 32'hC22);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        check("fl_valid", out_valid, 0);
        check("fl_occ0", occupancy, 0);
        check("fl_ctrl0", out_ctrl, 0);
        check("fl_stall_counted", stall_cnt, 4);
        out_ready = 1'b1;
        step();
        check("fl_no_ghost", out_valid, 0);

        // ---------------- flush with same-cycle accept ----------------
        out_ready = 1'b0;
        drive(1'b1, 5'd30, 8'h01, 32'hD30);
        step();
        flush = 1'b1;
        drive(1'b1, 5'd31, 8'h01, 32'hD31);
        check("fl2_rdy", in_ready, 1);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        check("fl2_valid", out_valid, 0);
        check("fl2_occ", occupancy, 0);
        step();
        check("fl2_no_ghost", out_valid, 0);
        check("fl2_stall5", stall_cnt, 5);

        // ---------------- stall saturation ----------------
        drive(1'b1, 5'd8, 8'h01, 32'hE40);
        step();
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        for (int i = 0; i < 20; i++) step();
        check("sat_15", stall_cnt, 15);
        check("sat_stable_op", out_opcode, 8);
        step();
        check("sat_hold", stall_cnt, 15);

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 5'd9, 8'h01, 32'hE41);
        step();
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        check("mr_occ2", occupancy, 2);
        rst = 1'b1;
        step();
        check("mr_valid", out_valid, 0);
        check("mr_out_a", out_a, 0);
        check("mr_stall", stall_cnt, 0);
        check("mr_occ", occupancy, 0);
        check("mr_rdy_in_rst", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 5'd6, 8'h01, 32'hF60);
        #1;
        check("mr_rdy_after", in_ready, 1);
        step();
        check("mr_first_valid", out_valid, 1);
        check("mr_first_op", out_opcode, 6);
        drive(1'b0, 5'd0, 8'h00, 32'h0);
        step();

        // ---------------- random traffic vs queue model ----------------
        sb.delete();
        for (int i = 0; i < 300; i++) begin
            logic mv, mr, mf, ifire, ofire;
            logic [OP_W-1:0]   op;
            logic [DATA_W-1:0] a;
            mv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            mf = ($urandom_range(0, 24) == 0);
            op = OP_W'(i);
            a  = $urandom;
            drive(mv, op, 8'h03, a);
            out_ready = mr;
            flush     = mf;
            #1;
            check("rnd_in_ready", in_ready, (sb.size() < 2));
            ifire = mv && (sb.size() < 2);
            ofire = mr && (sb.size() > 0);
            step();
            if (mf) begin
                sb.delete();
            end else begin
                if (ofire) void'(sb.pop_front());
                if (ifire) sb.push_back({op, a});
            end
            check("rnd_valid", out_valid, (sb.size() > 0));
            check("rnd_occ", occupancy, sb.size());
            if (sb.size() > 0) begin
                check("rnd_payload", {out_opcode, out_a}, sb[0]);
            end else begin
                check("rnd_bubble_ctrl", out_ctrl, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of operand A, operand B and immediate fields.
REQ-002 SHALL have parameter REG_W, default 4, width of register-index fields rd/rt.
REQ-003 SHALL have parameter OP_W, default 5, width of opcode field.
REQ-004 SHALL have parameter CTRL_W, default 8, width of packed control-signal field; bit 0 = reg_wr, bit 1 = mem_wr.
REQ-005 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-006 SHALL have ports: clk  in  1  single clock; all state updates on posedge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 in_valid  in  1  upstream stage holds a valid instruction.
REQ-009 in_ready  out  1  stage accepts the upstream instruction this cycle.
REQ-010 in_opcode / in_a / in_b / in_imm / in_rd / in_rt / in_ctrl  in  OP_W / DATA_W / DATA_W / DATA_W / REG_W / REG_W / CTRL_W  upstream payload.
REQ-011 flush  in  1  discards all held and incoming instructions, e.g. on a branch mispredict.
REQ-012 out_valid  out  1  downstream payload is valid.
REQ-013 out_ready  in  1  downstream stage consumes the payload this cycle.
REQ-014 out_opcode / out_a / out_b / out_imm / out_rd / out_rt / out_ctrl  out  same widths  registered payload.
REQ-015 occupancy  out  2  number of held entries (0..2).
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold two entries: an output register (OREG) driving out_* and a skid register (SREG), each with a valid bit.
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 SHALL drive in_ready = ~SREG.valid & ~rst, with no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: a payload fired at edge N SHALL appear on out_* after edge N when OREG is empty or draining.
REQ-021 Throughput SHALL be 1 instruction/cycle while out_ready=1 continuously.
REQ-022 If in_fire and (OREG empty or out_fire), then the input SHALL load OREG, or SREG contents SHALL load OREG if SREG is valid, with the input going to SREG.
REQ-023 If in_fire, OREG valid and no out_fire, then the input SHALL load SREG.
REQ-024 If out_fire with no in_fire, then SREG SHALL move to OREG if valid; otherwise OREG.valid SHALL clear.
REQ-025 Order SHALL be preserved strictly: no reordering, no duplication, no loss except on flush.
REQ-026 While OREG.valid=1 and out_ready=0, out_* SHALL remain stable.
REQ-027 When out_valid=0, out_ctrl SHALL read all-zero, so a bubble never asserts reg_wr/mem_wr; other out_* fields SHALL hold their last value.
REQ-028 flush=1 SHALL clear OREG.valid and SREG.valid at the next edge; a same-cycle in_fire SHALL be discarded; flush has priority over every transfer.
REQ-029 occupancy SHALL equal OREG.valid + SREG.valid (registered).
REQ-030 stall_cnt SHALL increment on each edge where out_valid & ~out_ready, saturate at 2^CNT_W-1, and never wrap.
REQ-031 Simultaneous flush and stall condition: stall_cnt SHALL still count that cycle.

Reset
REQ-032 While rst=1 at an edge: OREG.valid=0, SREG.valid=0, all out_* data=0, occupancy=0, stall_cnt=0; in_ready SHALL read 0 during rst.
REQ-033 rst SHALL override flush and all transfers; mid-stream reset discards held entries.
REQ-034 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-035 Streaming: out_ready=1, in_valid=1, opcodes 1,2,3 on consecutive cycles -> out_opcode 1,2,3 one cycle later, occupancy stays 1.
REQ-036 Backpressure: out_ready=0 with 3 inputs offered -> first two accepted, in_ready=0 on the third, occupancy=2, out_opcode stable; release -> outputs in order, third accepted.
REQ-037 Flush: occupancy=2 plus flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0, and the flushed inputs never appear.
REQ-038 Stall counter: CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt=15 and held.
REQ-039 Reset mid-operation: occupancy=2, rst pulsed 1 cycle -> out_valid=0, out_a=0, stall_cnt=0; in_ready=1 on the cycle after.
REQ-040 Random valid/ready traffic against a scoreboard -> zero mismatches, no reg_wr seen with out_valid=0.
